// File: rtl/bids_n.sv
// rtl/bids_n.sv - auction controller: key lock, per-bidder balances, bid rounds, winner scan
module bids_n #(
   parameter int DATAWIDTH  = 32,
   parameter int NUMBIDDERS = 4,
   parameter int IDXW       = $clog2(NUMBIDDERS)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            c_start,
   input  logic [3:0]                      c_op,
   input  logic [DATAWIDTH-1:0]            c_data,
   input  logic [IDXW-1:0]                 c_idx,
   input  logic [NUMBIDDERS-1:0]           bid,
   input  logic [NUMBIDDERS-1:0]           retract,
   input  logic [NUMBIDDERS*DATAWIDTH-1:0] bid_amt,
   output logic                            ready,
   output logic [2:0]                      err,
   output logic                            round_over,
   output logic [DATAWIDTH-1:0]            max_bid,
   output logic [NUMBIDDERS-1:0]           win,
   output logic [2*NUMBIDDERS-1:0]         bidder_err,
   output logic [NUMBIDDERS*DATAWIDTH-1:0] balance
);
   typedef enum logic [2:0] {
      S_UNLOCKED = 3'd0, S_LOCKED = 3'd1, S_COOLDOWN = 3'd2,
      S_ROUND    = 3'd3, S_SCAN   = 3'd4, S_DONE     = 3'd5
   } state_t;

   localparam logic [3:0] OP_NO_OP = 4'd0, OP_UNLOCK = 4'd1, OP_LOCK = 4'd2, OP_LOAD = 4'd3;
   localparam logic [3:0] OP_SETMASK = 4'd4, OP_SETTIMER = 4'd5, OP_SETCHARGE = 4'd6;
   localparam logic [2:0] E_NOERROR = 3'd0, E_BADKEY = 3'd1, E_ALREADYUNLOCKED = 3'd2;
   localparam logic [2:0] E_CSTART = 3'd3, E_INVALID_OP = 3'd4, E_ALREADYLOCKED = 3'd5;
   localparam logic [1:0] B_NONE = 2'd0, B_INVALIDREQUEST = 2'd1;
   localparam logic [1:0] B_INSUFFICIENTFUNDS = 2'd2, B_BIDTOOLOW = 2'd3;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMBIDDERS - 1);
   localparam logic [IDXW:0]   NB_LIM   = (IDXW+1)'(NUMBIDDERS);

   state_t                 r_state, w_state_nxt;
   logic [DATAWIDTH-1:0]   r_key, r_timer_val, r_cdtimer, r_charge, r_max_bid, r_best_val;
   logic [NUMBIDDERS-1:0]  r_mask, r_win;
   logic [IDXW-1:0]        r_scan_idx, r_best_idx;
   logic                   r_found;
   logic [DATAWIDTH-1:0]   r_balance [NUMBIDDERS];
   logic [DATAWIDTH-1:0]   r_lastbid [NUMBIDDERS];

   logic [DATAWIDTH-1:0]   w_amt     [NUMBIDDERS];
   logic [DATAWIDTH-1:0]   w_bal_nxt [NUMBIDDERS];
   logic [DATAWIDTH-1:0]   w_lb_nxt  [NUMBIDDERS];
   logic [1:0]             w_berr    [NUMBIDDERS];
   logic [NUMBIDDERS-1:0]  w_accept;
   logic [DATAWIDTH-1:0]   w_max_nxt;
   logic                   w_idx_bad, w_take, w_fin_found;
   logic [IDXW-1:0]        w_fin_idx;

   assign w_idx_bad = ({1'b0, c_idx} >= NB_LIM);
   assign max_bid   = r_max_bid;
   assign win       = r_win;

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_UNLOCKED;
      else          r_state <= w_state_nxt;
   end

   // next-state logic; c_start wins over any opcode in LOCKED
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_UNLOCKED: if (!c_start && c_op == OP_LOCK) w_state_nxt = S_LOCKED;
         S_LOCKED: begin
            if (c_start) w_state_nxt = S_ROUND;
            else if (c_op == OP_UNLOCK)
               w_state_nxt = (c_data == r_key) ? S_UNLOCKED : S_COOLDOWN;
         end
         S_COOLDOWN: if (r_cdtimer == '0) w_state_nxt = S_LOCKED;
         S_ROUND:    if (!c_start) w_state_nxt = S_SCAN;
         S_SCAN:     if (r_scan_idx == LAST_IDX) w_state_nxt = S_DONE;
         S_DONE:     w_state_nxt = S_LOCKED;
         default:    w_state_nxt = S_UNLOCKED;
      endcase
   end

   // state-derived outputs, controller error and packed per-bidder outputs
   always_comb begin
      ready      = (r_state == S_LOCKED);
      round_over = (r_state == S_DONE);
      err        = E_NOERROR;
      case (r_state)
         S_UNLOCKED: begin
            if (c_start) err = E_CSTART;
            else case (c_op)
               OP_UNLOCK: err = E_ALREADYUNLOCKED;
               OP_LOAD:   if (w_idx_bad) err = E_INVALID_OP;
               OP_NO_OP, OP_LOCK, OP_SETMASK, OP_SETTIMER, OP_SETCHARGE: ;
               default:   err = E_INVALID_OP;
            endcase
         end
         S_LOCKED: begin
            if (!c_start) case (c_op)
               OP_NO_OP, OP_UNLOCK: ;
               OP_LOCK: err = E_ALREADYLOCKED;
               default: err = E_INVALID_OP;
            endcase
         end
         S_COOLDOWN: err = E_BADKEY;
         default: ;
      endcase
      for (int i = 0; i < NUMBIDDERS; i++) begin
         bidder_err[2*i +: 2]             = w_berr[i];
         balance[i*DATAWIDTH +: DATAWIDTH] = r_balance[i];
      end
   end

   // bid qualification against the max_bid held at the start of the cycle
   always_comb begin
      for (int i = 0; i < NUMBIDDERS; i++) begin
         w_amt[i]  = bid_amt[i*DATAWIDTH +: DATAWIDTH];
         w_berr[i] = B_NONE;
         if (bid[i]) begin
            if (r_state != S_ROUND || !r_mask[i]) w_berr[i] = B_INVALIDREQUEST;
            else if (({1'b0, w_amt[i]} + {1'b0, r_charge}) > {1'b0, r_balance[i]})
               w_berr[i] = B_INSUFFICIENTFUNDS;
            else if (w_amt[i] <= r_max_bid) w_berr[i] = B_BIDTOOLOW;
         end
         w_accept[i] = bid[i] && (r_state == S_ROUND) && (w_berr[i] == B_NONE);
      end
   end

   // next balances/standing bids: LOAD, accepted bids, retracts, end-of-round refunds
   always_comb begin
      w_max_nxt = '0;
      for (int i = 0; i < NUMBIDDERS; i++) begin
         w_bal_nxt[i] = r_balance[i];
         w_lb_nxt[i]  = r_lastbid[i];
         case (r_state)
            S_UNLOCKED: begin
               if (!c_start && c_op == OP_LOAD && !w_idx_bad && c_idx == IDXW'(i))
                  w_bal_nxt[i] = c_data;
            end
            S_ROUND: begin
               if (w_accept[i]) begin
                  w_bal_nxt[i] = r_balance[i] - w_amt[i] - r_charge + r_lastbid[i];
                  w_lb_nxt[i]  = w_amt[i];
               end else if (retract[i] && !bid[i]) begin
                  w_bal_nxt[i] = r_balance[i] + r_lastbid[i];
                  w_lb_nxt[i]  = '0;
               end
            end
            S_DONE: begin
               if (!r_win[i]) w_bal_nxt[i] = r_balance[i] + r_lastbid[i];
               w_lb_nxt[i] = '0;
            end
            default: ;
         endcase
         if (w_lb_nxt[i] > w_max_nxt) w_max_nxt = w_lb_nxt[i];
      end
   end

   // final comparison of the scan, used to form the winner on the last scan cycle
   always_comb begin
      w_take      = (r_lastbid[r_scan_idx] > r_best_val);
      w_fin_found = r_found | w_take;
      w_fin_idx   = w_take ? r_scan_idx : r_best_idx;
   end

   // balance, standing bid and max_bid registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUMBIDDERS; i++) begin
            r_balance[i] <= '0;
            r_lastbid[i] <= '0;
         end
         r_max_bid <= '0;
      end else begin
         for (int i = 0; i < NUMBIDDERS; i++) begin
            r_balance[i] <= w_bal_nxt[i];
            r_lastbid[i] <= w_lb_nxt[i];
         end
         r_max_bid <= w_max_nxt;
      end
   end

   // configuration registers and cooldown timer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_key       <= '0;
         r_mask      <= '1;
         r_timer_val <= DATAWIDTH'(15);
         r_cdtimer   <= DATAWIDTH'(15);
         r_charge    <= DATAWIDTH'(1);
      end else begin
         if (r_state == S_UNLOCKED && !c_start) begin
            case (c_op)
               OP_LOCK:      r_key       <= c_data;
               OP_SETMASK:   r_mask      <= c_data[NUMBIDDERS-1:0];
               OP_SETTIMER:  r_timer_val <= c_data;
               OP_SETCHARGE: r_charge    <= c_data;
               default: ;
            endcase
         end
         if (r_state == S_LOCKED && !c_start && c_op == OP_UNLOCK && c_data != r_key)
            r_cdtimer <= r_timer_val;
         else if (r_state == S_COOLDOWN && r_cdtimer != '0)
            r_cdtimer <= r_cdtimer - 1'b1;
      end
   end

   // winner scan: one index per cycle, strict greater-than keeps the lowest index on ties
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_scan_idx <= '0;
         r_best_val <= '0;
         r_best_idx <= '0;
         r_found    <= 1'b0;
         r_win      <= '0;
      end else if (r_state == S_ROUND) begin
         r_scan_idx <= '0;
         r_best_val <= '0;
         r_best_idx <= '0;
         r_found    <= 1'b0;
      end else if (r_state == S_SCAN) begin
         r_scan_idx <= r_scan_idx + 1'b1;
         if (w_take) begin
            r_best_val <= r_lastbid[r_scan_idx];
            r_best_idx <= r_scan_idx;
            r_found    <= 1'b1;
         end
         if (r_scan_idx == LAST_IDX)
            r_win <= w_fin_found ? (NUMBIDDERS'(1) << w_fin_idx) : '0;
      end else if (r_state == S_DONE) begin
         r_win <= '0;
      end
   end
endmodule

// File: tb/tb_bids_n.sv
// tb/tb_bids_n.sv - randomized self-checking bench for bids_n against a transaction-level auction model
module tb_bids_n;
   localparam int DW = 32;
   localparam int NB = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            c_start;
   logic [3:0]      c_op;
   logic [DW-1:0]   c_data;
   logic [IW-1:0]   c_idx;
   logic [NB-1:0]   bid, retract;
   logic [NB*DW-1:0] bid_amt;
   logic            ready;
   logic [2:0]      err;
   logic            round_over;
   logic [DW-1:0]   max_bid;
   logic [NB-1:0]   win;
   logic [2*NB-1:0] bidder_err;
   logic [NB*DW-1:0] balance;

   bids_n #(.DATAWIDTH(DW), .NUMBIDDERS(NB)) dut (
      .clk(clk), .reset_n(reset_n), .c_start(c_start), .c_op(c_op), .c_data(c_data),
      .c_idx(c_idx), .bid(bid), .retract(retract), .bid_amt(bid_amt), .ready(ready),
      .err(err), .round_over(round_over), .max_bid(max_bid), .win(win),
      .bidder_err(bidder_err), .balance(balance)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   longint        m_bal [NB];
   longint        m_lb  [NB];
   logic [NB-1:0] m_mask;
   longint        m_charge;
   logic [DW-1:0] m_key;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      c_start = 1'b0; c_op = 4'd0; c_data = '0; c_idx = '0;
      bid = '0; retract = '0; bid_amt = '0;
      #1;
   endtask

   task automatic m_reset();
      for (int i = 0; i < NB; i++) begin
         m_bal[i] = 0;
         m_lb[i]  = 0;
      end
      m_mask = '1; m_charge = 1; m_key = '0;
   endtask

   function automatic logic [NB*DW-1:0] pack4(input logic [DW-1:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic chk_regs(input string tag);
      longint mx = 0;
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("%s_bal%0d", tag, i), balance[i*DW +: DW], m_bal[i]);
         if (m_lb[i] > mx) mx = m_lb[i];
      end
      chk({tag, "_max"}, max_bid, mx);
   endtask

   task automatic do_op(input logic [3:0] op, input logic [DW-1:0] d, input int idx, input logic [2:0] e);
      c_op = op; c_data = d; c_idx = IW'(idx);
      #1;
      chk($sformatf("err_op%0d", op), err, e);
      step();
      idle();
   endtask

   task automatic badkey(input logic [DW-1:0] k, input int exp_n);
      int n;
      c_op = 4'd1; c_data = k;
      #1;
      step();
      idle();
      chk("rdy_cooldown", ready, 0);
      n = 0;
      while (err == 3'd1 && n < 100) begin
         n++;
         step();
      end
      chk("cooldown_len", n, exp_n);
      chk("rdy_after_cd", ready, 1);
   endtask

   task automatic start_round();
      c_start = 1'b1;
      #1;
      chk("rdy_pre_round", ready, 1);
      chk("err_start", err, 0);
      step();
      chk("rdy_in_round", ready, 0);
   endtask

   // one ROUND cycle: expected bidder errors come from the rules applied to the model
   task automatic rcycle(input logic [NB-1:0] b, input logic [NB-1:0] r, input logic [NB*DW-1:0] amts);
      longint pre, amt;
      logic [1:0] e;
      bid = b; retract = r; bid_amt = amts;
      #1;
      pre = 0;
      for (int i = 0; i < NB; i++) if (m_lb[i] > pre) pre = m_lb[i];
      for (int i = 0; i < NB; i++) begin
         amt = amts[i*DW +: DW];
         if (!b[i]) e = 2'd0;
         else if (!m_mask[i]) e = 2'd1;
         else if (amt + m_charge > m_bal[i]) e = 2'd2;
         else if (amt <= pre) e = 2'd3;
         else e = 2'd0;
         chk($sformatf("berr%0d", i), bidder_err[2*i +: 2], e);
         if (b[i] && e == 2'd0) begin
            m_bal[i] = m_bal[i] - amt - m_charge + m_lb[i];
            m_lb[i]  = amt;
         end else if (!b[i] && r[i]) begin
            m_bal[i] = m_bal[i] + m_lb[i];
            m_lb[i]  = 0;
         end
      end
      step();
      bid = '0; retract = '0; bid_amt = '0;
      #1;
      chk_regs("rnd");
   endtask

   task automatic finish_round();
      int n, w;
      bit seen;
      longint best;
      logic [NB-1:0] ew;
      c_start = 1'b0;
      #1;
      n = 0; seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         step();
         n++;
         seen = round_over;
      end
      chk("ro_seen", seen, 1);
      chk("ro_latency", n, NB + 1);
      best = 0; w = -1;
      for (int i = 0; i < NB; i++) if (m_lb[i] > best) begin best = m_lb[i]; w = i; end
      ew = '0;
      if (w >= 0) ew[w] = 1'b1;
      chk("win", win, ew);
      chk_regs("done");
      for (int i = 0; i < NB; i++) begin
         if (i != w) m_bal[i] = m_bal[i] + m_lb[i];
         m_lb[i] = 0;
      end
      step();
      chk("ro_after", round_over, 0);
      chk("win_after", win, 0);
      chk("rdy_after", ready, 1);
      chk_regs("post");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] d;
      reset_n = 1'b0;
      idle();
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_err", err, 0);
      chk("rst_ro", round_over, 0);
      chk("rst_berr", bidder_err, 0);
      chk("rst_win", win, 0);
      chk_regs("rst");
      reset_n = 1'b1;
      step();

      // controller errors while unlocked; c_start suppresses the LOCK opcode
      c_start = 1'b1; c_op = 4'd2; c_data = 32'h5;
      #1;
      chk("err_cstart_unl", err, 3);
      step();
      idle();
      chk("rdy_still_unl", ready, 0);
      c_op = 4'd1;
      #1;
      chk("err_already_unl", err, 2);
      c_op = 4'd9;
      #1;
      chk("err_invalid_unl", err, 4);
      idle();
      bid = 4'b0001; bid_amt = pack4(5, 0, 0, 0);
      #1;
      chk("berr_unl", bidder_err, 8'b0000_0001);
      step();
      idle();
      chk_regs("bid_unl");

      for (int i = 0; i < NB; i++) begin
         do_op(4'd3, 100, i, 0);
         m_bal[i] = 100;
      end
      chk_regs("load");
      do_op(4'd4, 32'h7, 0, 0); m_mask = 4'b0111;
      do_op(4'd2, 32'hA5, 0, 0); m_key = 32'hA5;
      chk("rdy_locked", ready, 1);
      c_op = 4'd2;
      #1;
      chk("err_already_lk", err, 5);
      c_op = 4'd4;
      #1;
      chk("err_invalid_lk", err, 4);
      idle();
      bid = 4'b0001; bid_amt = pack4(50, 0, 0, 0);
      #1;
      chk("berr_locked", bidder_err, 8'b0000_0001);
      step();
      idle();
      chk_regs("bid_locked");

      badkey(32'h0, 16);
      do_op(4'd1, 32'hA5, 0, 0);
      chk("rdy_unlocked", ready, 0);
      c_op = 4'd1;
      #1;
      chk("err_unl_again", err, 2);
      idle();
      do_op(4'd2, 32'hA5, 0, 0);

      // directed round: low bid, retract, masked bidder, funds boundary
      start_round();
      rcycle(4'b0001, 4'b0000, pack4(10, 0, 0, 0));
      rcycle(4'b0100, 4'b0000, pack4(0, 0, 50, 0));
      rcycle(4'b0000, 4'b0100, pack4(0, 0, 0, 0));
      rcycle(4'b0010, 4'b0000, pack4(0, 20, 0, 0));
      rcycle(4'b0001, 4'b0000, pack4(15, 0, 0, 0));
      rcycle(4'b1000, 4'b0000, pack4(0, 0, 0, 40));
      rcycle(4'b0010, 4'b0000, pack4(0, 79, 0, 0));
      finish_round();

      // simultaneous equal bids
      start_round();
      rcycle(4'b0011, 4'b0000, pack4(30, 30, 0, 0));
      finish_round();

      // cooldown length follows timer_val, including zero
      do_op(4'd1, 32'hA5, 0, 0);
      do_op(4'd5, 32'h0, 0, 0);
      do_op(4'd2, 32'hA5, 0, 0);
      badkey(32'h1, 1);
      do_op(4'd1, 32'hA5, 0, 0);
      do_op(4'd5, 32'h3, 0, 0);
      do_op(4'd2, 32'hA5, 0, 0);
      badkey(32'h7, 4);

      // randomized rounds
      for (int r = 0; r < 6; r++) begin
         do_op(4'd1, m_key, 0, 0);
         for (int i = 0; i < NB; i++) begin
            d = DW'($urandom_range(0, 200));
            do_op(4'd3, d, i, 0);
            m_bal[i] = d;
         end
         d = $urandom;
         do_op(4'd4, d, 0, 0); m_mask = d[NB-1:0];
         d = DW'($urandom_range(0, 3));
         do_op(4'd6, d, 0, 0); m_charge = d;
         d = $urandom;
         do_op(4'd2, d, 0, 0); m_key = d;
         start_round();
         for (int c = 0; c < 12; c++) begin
            rcycle(NB'($urandom) & NB'($urandom),
                   NB'($urandom) & NB'($urandom) & NB'($urandom),
                   pack4(DW'($urandom_range(0, 120)), DW'($urandom_range(0, 120)),
                         DW'($urandom_range(0, 120)), DW'($urandom_range(0, 120))));
         end
         finish_round();
      end

      // asynchronous reset in the middle of the scan
      start_round();
      rcycle(4'b1111, 4'b0000, pack4(1, 2, 3, 4));
      c_start = 1'b0;
      step();
      step();
      #2;
      reset_n = 1'b0;
      #1;
      m_reset();
      chk("arst_ready", ready, 0);
      chk("arst_err", err, 0);
      chk("arst_ro", round_over, 0);
      chk("arst_win", win, 0);
      chk("arst_berr", bidder_err, 0);
      chk_regs("arst");
      step();
      reset_n = 1'b1;
      idle();
      step();

      do_op(4'd3, 50, 3, 0); m_bal[3] = 50;
      do_op(4'd2, 32'h0, 0, 0);
      badkey(32'h9, 16);
      start_round();
      rcycle(4'b1000, 4'b0000, pack4(0, 0, 0, 10));
      finish_round();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
